// File: rtl/piece_controller_if.sv
// Command handshake and result bundle between input/gravity logic and the
// piece controller. The master issues commands, the slave (the controller)
// accepts them and reports the outcome.
interface piece_controller_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [2:0] cmd_block;
    logic       cmd_ready;
    logic       result_valid;
    logic       result_ok;
    logic       landed;

    modport master (
        output cmd_valid,
        output cmd,
        output cmd_block,
        input  cmd_ready,
        input  result_valid,
        input  result_ok,
        input  landed
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  cmd_block,
        output cmd_ready,
        output result_valid,
        output result_ok,
        output landed
    );
endinterface

// File: rtl/piece_controller.sv
// Falling-tetromino sequencer. Takes one command at a time, looks up the
// candidate shape offsets, probes the four candidate cells against the board
// bounds and board memory, then commits or rejects the move. Every command
// takes the same number of cycles, including ones rejected up front.
module piece_controller #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 3,
    parameter int XW      = 4,
    parameter int YW      = 5
) (
    input  logic                clock,
    input  logic                resetn,
    piece_controller_if.slave   cmd_if,
    output logic [2:0]          lut_block,
    output logic [1:0]          lut_rotation,
    input  logic [7:0]          lut_x,
    input  logic [7:0]          lut_y,
    output logic                brd_rd_en,
    output logic [XW-1:0]       brd_rd_x,
    output logic [YW-1:0]       brd_rd_y,
    input  logic                brd_rd_data,
    output logic [XW-1:0]       piece_x,
    output logic [YW-1:0]       piece_y,
    output logic [2:0]          piece_block,
    output logic [1:0]          piece_rot,
    output logic                active,
    output logic                game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] CMD_DOWN  = 3'd3;
    localparam logic [2:0] CMD_SPAWN = 3'd4;

    localparam logic signed [XW:0] ONE_X     = (XW+1)'(1);
    localparam logic signed [YW:0] ONE_Y     = (YW+1)'(1);
    localparam logic signed [XW:0] SPAWN_X_S = (XW+1)'(SPAWN_X);
    localparam logic signed [XW:0] BOARD_W_S = (XW+1)'(BOARD_W);
    localparam logic signed [YW:0] BOARD_H_S = (YW+1)'(BOARD_H);

    state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] cmd_q, cmd_d;
    logic [2:0] blk_q, blk_d;
    logic reject_q, reject_d;
    logic signed [XW:0] cand_x_q, cand_x_d;
    logic signed [YW:0] cand_y_q, cand_y_d;
    logic [1:0] cand_rot_q, cand_rot_d;
    logic [2:0] cand_blk_q, cand_blk_d;
    logic [7:0] off_x_q, off_x_d;
    logic [7:0] off_y_q, off_y_d;
    logic coll_q, coll_d;
    logic rd_pend_q, rd_pend_d;
    logic ok_q, ok_d;
    logic landed_q, landed_d;
    logic [XW-1:0] piece_x_q, piece_x_d;
    logic [YW-1:0] piece_y_q, piece_y_d;
    logic [1:0] piece_rot_q, piece_rot_d;
    logic [2:0] piece_block_q, piece_block_d;
    logic active_q, active_d;
    logic game_over_q, game_over_d;

    logic signed [XW:0] next_x;
    logic signed [YW:0] next_y;
    logic [1:0] next_rot;
    logic [2:0] next_blk;
    logic signed [XW:0] cell_x;
    logic signed [YW:0] cell_y;
    logic cell_oob;
    logic read_hit;
    logic final_coll;

    // Candidate placement derived from the latched command and committed piece.
    always_comb begin
        next_x   = $signed({1'b0, piece_x_q});
        next_y   = $signed({1'b0, piece_y_q});
        next_rot = piece_rot_q;
        next_blk = piece_block_q;
        case (cmd_q)
            3'd0: next_x = $signed({1'b0, piece_x_q}) - ONE_X;
            3'd1: next_x = $signed({1'b0, piece_x_q}) + ONE_X;
            3'd2: next_rot = piece_rot_q + 2'd1;
            3'd3: next_y = $signed({1'b0, piece_y_q}) + ONE_Y;
            3'd4: begin
                next_x   = SPAWN_X_S;
                next_y   = '0;
                next_rot = 2'd0;
                next_blk = blk_q;
            end
            default: ;
        endcase
    end

    // Address of the cell probed this CHECK cycle, with bounds classification.
    always_comb begin
        cell_x   = cand_x_q + $signed({{(XW-1){1'b0}}, off_x_q[{idx_q, 1'b0} +: 2]});
        cell_y   = cand_y_q + $signed({{(YW-1){1'b0}}, off_y_q[{idx_q, 1'b0} +: 2]});
        cell_oob = cell_x[XW] || (cell_x >= BOARD_W_S) || (cell_y >= BOARD_H_S);
        brd_rd_en = (state_q == S_CHECK) && !reject_q && !cell_oob;
        brd_rd_x  = brd_rd_en ? cell_x[XW-1:0] : '0;
        brd_rd_y  = brd_rd_en ? cell_y[YW-1:0] : '0;
    end

    // Sequencing and commit decision for the command in flight.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cmd_d         = cmd_q;
        blk_d         = blk_q;
        reject_d      = reject_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        cand_rot_d    = cand_rot_q;
        cand_blk_d    = cand_blk_q;
        off_x_d       = off_x_q;
        off_y_d       = off_y_q;
        coll_d        = coll_q;
        rd_pend_d     = 1'b0;
        ok_d          = ok_q;
        landed_d      = landed_q;
        piece_x_d     = piece_x_q;
        piece_y_d     = piece_y_q;
        piece_rot_d   = piece_rot_q;
        piece_block_d = piece_block_q;
        active_d      = active_q;
        game_over_d   = game_over_q;

        read_hit   = rd_pend_q && brd_rd_data;
        final_coll = coll_q || read_hit;

        case (state_q)
            S_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    cmd_d    = cmd_if.cmd;
                    blk_d    = cmd_if.cmd_block;
                    reject_d = game_over_q
                            || (cmd_if.cmd > CMD_SPAWN)
                            || ((cmd_if.cmd != CMD_SPAWN) && !active_q)
                            || ((cmd_if.cmd == CMD_SPAWN) && active_q);
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cand_x_d   = next_x;
                cand_y_d   = next_y;
                cand_rot_d = next_rot;
                cand_blk_d = next_blk;
                off_x_d    = lut_x;
                off_y_d    = lut_y;
                coll_d     = reject_q;
                idx_d      = 2'd0;
                state_d    = S_CHECK;
            end
            S_CHECK: begin
                rd_pend_d = brd_rd_en;
                coll_d    = coll_q || read_hit || cell_oob;
                idx_d     = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                ok_d     = !final_coll;
                landed_d = final_coll && !reject_q && (cmd_q == CMD_DOWN);
                if (!final_coll) begin
                    piece_x_d     = cand_x_q[XW-1:0];
                    piece_y_d     = cand_y_q[YW-1:0];
                    piece_rot_d   = cand_rot_q;
                    piece_block_d = cand_blk_q;
                    if (cmd_q == CMD_SPAWN) begin
                        active_d = 1'b1;
                    end
                end else if (!reject_q) begin
                    if (cmd_q == CMD_DOWN) begin
                        active_d = 1'b0;
                    end
                    if (cmd_q == CMD_SPAWN) begin
                        active_d    = 1'b0;
                        game_over_d = 1'b1;
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight command.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cmd_q         <= '0;
            blk_q         <= '0;
            reject_q      <= 1'b0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            cand_rot_q    <= '0;
            cand_blk_q    <= '0;
            off_x_q       <= '0;
            off_y_q       <= '0;
            coll_q        <= 1'b0;
            rd_pend_q     <= 1'b0;
            ok_q          <= 1'b0;
            landed_q      <= 1'b0;
            piece_x_q     <= '0;
            piece_y_q     <= '0;
            piece_rot_q   <= '0;
            piece_block_q <= '0;
            active_q      <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cmd_q         <= cmd_d;
            blk_q         <= blk_d;
            reject_q      <= reject_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            cand_rot_q    <= cand_rot_d;
            cand_blk_q    <= cand_blk_d;
            off_x_q       <= off_x_d;
            off_y_q       <= off_y_d;
            coll_q        <= coll_d;
            rd_pend_q     <= rd_pend_d;
            ok_q          <= ok_d;
            landed_q      <= landed_d;
            piece_x_q     <= piece_x_d;
            piece_y_q     <= piece_y_d;
            piece_rot_q   <= piece_rot_d;
            piece_block_q <= piece_block_d;
            active_q      <= active_d;
            game_over_q   <= game_over_d;
        end
    end

    assign lut_block           = next_blk;
    assign lut_rotation        = next_rot;
    assign cmd_if.cmd_ready    = (state_q == S_IDLE);
    assign cmd_if.result_valid = (state_q == S_DONE);
    assign cmd_if.result_ok    = (state_q == S_DONE) && ok_q;
    assign cmd_if.landed       = (state_q == S_DONE) && landed_q;
    assign piece_x             = piece_x_q;
    assign piece_y             = piece_y_q;
    assign piece_rot           = piece_rot_q;
    assign piece_block         = piece_block_q;
    assign active              = active_q;
    assign game_over           = game_over_q;

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: provides the shape LUT and a board memory,
// runs a directed command table, corner-case sequences and a random run
// checked against a command-level game model.
module tb_piece_controller;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] lut_block;
    logic [1:0] lut_rotation;
    logic [7:0] lut_x;
    logic [7:0] lut_y;
    logic       brd_rd_en;
    logic [3:0] brd_rd_x;
    logic [4:0] brd_rd_y;
    logic       brd_rd_data;
    logic [3:0] piece_x;
    logic [4:0] piece_y;
    logic [2:0] piece_block;
    logic [1:0] piece_rot;
    logic       active;
    logic       game_over;

    piece_controller_if cmd_if ();

    piece_controller dut (
        .clock        (clock),
        .resetn       (resetn),
        .cmd_if       (cmd_if),
        .lut_block    (lut_block),
        .lut_rotation (lut_rotation),
        .lut_x        (lut_x),
        .lut_y        (lut_y),
        .brd_rd_en    (brd_rd_en),
        .brd_rd_x     (brd_rd_x),
        .brd_rd_y     (brd_rd_y),
        .brd_rd_data  (brd_rd_data),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .piece_block  (piece_block),
        .piece_rot    (piece_rot),
        .active       (active),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    bit board [20][10];
    int reads_seen;
    int read_log [$];

    // Reference game model state.
    logic [3:0] m_x;
    logic [4:0] m_y;
    int  m_rot, m_blk;
    bit  m_act, m_go;
    bit  exp_ok, exp_land;
    int  exp_reads;

    typedef struct {
        int valid_at;
        bit ok;
        bit land;
        int x, y, rot, blk;
        bit act, go, rdy;
    } cap_t;
    cap_t cap;

    typedef struct {
        logic [2:0] c;
        logic [2:0] b;
        bit ok;
        bit land;
        int x, y, rot;
        bit act;
    } vec_t;
    vec_t vecs [11];

    // Tetromino cells inside a 4x4 box; rotation turns the box a quarter turn.
    function automatic logic [15:0] shapeOffsets(input logic [2:0] b, input logic [1:0] r);
        int xs [4];
        int ys [4];
        int t;
        logic [15:0] res;
        case (b)
            3'd0: begin xs = '{0, 1, 2, 3}; ys = '{0, 0, 0, 0}; end
            3'd1: begin xs = '{0, 0, 1, 2}; ys = '{0, 1, 1, 1}; end
            3'd2: begin xs = '{2, 0, 1, 2}; ys = '{0, 1, 1, 1}; end
            3'd4: begin xs = '{1, 2, 0, 1}; ys = '{0, 0, 1, 1}; end
            3'd5: begin xs = '{1, 0, 1, 2}; ys = '{0, 1, 1, 1}; end
            3'd6: begin xs = '{0, 1, 1, 2}; ys = '{0, 0, 1, 1}; end
            default: begin xs = '{0, 1, 0, 1}; ys = '{0, 0, 1, 1}; end
        endcase
        if (b != 3'd3 && b != 3'd7) begin
            for (int k = 0; k < int'(r); k++) begin
                for (int i = 0; i < 4; i++) begin
                    t = xs[i];
                    xs[i] = 3 - ys[i];
                    ys[i] = t;
                end
            end
        end
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[2*i +: 2]     = 2'(xs[i]);
            res[8 + 2*i +: 2] = 2'(ys[i]);
        end
        return res;
    endfunction

    always_comb {lut_y, lut_x} = shapeOffsets(lut_block, lut_rotation);

    // Board memory: one-cycle read latency; every read address must lie on the board.
    always @(posedge clock) begin
        if (brd_rd_en) begin
            reads_seen = reads_seen + 1;
            read_log.push_back(int'(brd_rd_x) * 32 + int'(brd_rd_y));
            checks++;
            if (brd_rd_x >= 4'd10 || brd_rd_y >= 5'd20) begin
                errors++;
                $display("[TB] FAIL rd_bounds: got x=%0d y=%0d, required x<10 y<20", brd_rd_x, brd_rd_y);
            end
        end
        brd_rd_data <= (brd_rd_en && brd_rd_x < 4'd10 && brd_rd_y < 5'd20) ? board[brd_rd_y][brd_rd_x] : 1'b0;
    end

    task automatic checkOutput(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act_v, exp_v);
        end
    endtask

    task automatic clearBoard();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                board[y][x] = 1'b0;
    endtask

    task automatic randomBoard();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                board[y][x] = (y >= 8 && $urandom_range(0, 4) == 0) || (y < 2 && $urandom_range(0, 40) == 0);
    endtask

    task automatic modelReset();
        m_x = '0; m_y = '0; m_rot = 0; m_blk = 0; m_act = 1'b0; m_go = 1'b0;
    endtask

    // Command-level rules of the game, independent of cycle timing.
    task automatic modelStep(input logic [2:0] c, input logic [2:0] b);
        int cx, cy, cr, cb, gx, gy;
        logic [15:0] offs;
        bit rej, hit;
        rej = m_go || (c > 3'd4) || (c != 3'd4 && !m_act) || (c == 3'd4 && m_act);
        cx = int'(m_x); cy = int'(m_y); cr = m_rot; cb = m_blk;
        case (c)
            3'd0: cx = int'(m_x) - 1;
            3'd1: cx = int'(m_x) + 1;
            3'd2: cr = (m_rot + 1) % 4;
            3'd3: cy = int'(m_y) + 1;
            3'd4: begin cx = 3; cy = 0; cr = 0; cb = int'(b); end
            default: ;
        endcase
        exp_reads = 0;
        exp_land  = 1'b0;
        hit       = rej;
        if (!rej) begin
            offs = shapeOffsets(3'(cb), 2'(cr));
            for (int i = 0; i < 4; i++) begin
                gx = cx + int'(offs[2*i +: 2]);
                gy = cy + int'(offs[8 + 2*i +: 2]);
                if (gx < 0 || gx >= 10 || gy >= 20) hit = 1'b1;
                else begin
                    exp_reads++;
                    if (board[gy][gx]) hit = 1'b1;
                end
            end
        end
        exp_ok = !hit;
        if (!hit) begin
            m_x = 4'(cx); m_y = 5'(cy); m_rot = cr; m_blk = cb;
            if (c == 3'd4) m_act = 1'b1;
        end else if (!rej) begin
            if (c == 3'd3) begin exp_land = 1'b1; m_act = 1'b0; end
            if (c == 3'd4) begin m_go = 1'b1; m_act = 1'b0; end
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        checkOutput("rst_piece_x", piece_x, 0);
        checkOutput("rst_piece_y", piece_y, 0);
        checkOutput("rst_piece_rot", piece_rot, 0);
        checkOutput("rst_piece_block", piece_block, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_game_over", game_over, 0);
        checkOutput("rst_result", {cmd_if.result_valid, cmd_if.result_ok, cmd_if.landed}, 0);
        checkOutput("rst_rd_en", brd_rd_en, 0);
        checkOutput("rst_cmd_ready", cmd_if.cmd_ready, 1);
        modelReset();
    endtask

    // Issue one command and capture the DUT outputs in the completion cycle.
    task automatic applyStimulus(input logic [2:0] c, input logic [2:0] b);
        @(negedge clock);
        checkOutput("cmd_ready_idle", cmd_if.cmd_ready, 1);
        reads_seen = 0;
        read_log.delete();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c;
        cmd_if.cmd_block = b;
        @(posedge clock);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cap.valid_at = -1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (cmd_if.result_valid && cap.valid_at < 0) cap.valid_at = k;
            if (k == 7) begin
                cap.ok   = cmd_if.result_ok;
                cap.land = cmd_if.landed;
                cap.x    = int'(piece_x);
                cap.y    = int'(piece_y);
                cap.rot  = int'(piece_rot);
                cap.blk  = int'(piece_block);
                cap.act  = active;
                cap.go   = game_over;
                cap.rdy  = cmd_if.cmd_ready;
            end
            cmd_if.cmd_valid = (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_if.cmd       = 3'($urandom);
            cmd_if.cmd_block = 3'($urandom);
        end
        @(negedge clock);
        checkOutput("result_pulse_end", cmd_if.result_valid, 0);
    endtask

    task automatic doCommand(input logic [2:0] c, input logic [2:0] b);
        modelStep(c, b);
        applyStimulus(c, b);
        checkOutput("latency", cap.valid_at, 7);
        checkOutput("result_ok", cap.ok, exp_ok);
        checkOutput("landed", cap.land, exp_land);
        checkOutput("piece_x", cap.x, int'(m_x));
        checkOutput("piece_y", cap.y, int'(m_y));
        checkOutput("piece_rot", cap.rot, m_rot);
        checkOutput("piece_block", cap.blk, m_blk);
        checkOutput("active", cap.act, m_act);
        checkOutput("game_over", cap.go, m_go);
        checkOutput("ready_in_done", cap.rdy, 0);
        checkOutput("read_count", reads_seen, exp_reads);
    endtask

    initial begin
        int seen;
        logic [2:0] c;
        int r;

        resetn = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = '0;
        cmd_if.cmd_block = '0;
        reads_seen = 0;
        clearBoard();
        modelReset();

        vecs[0]  = '{3'd4, 3'd3, 1'b1, 1'b0, 3, 0, 0, 1'b1};
        vecs[1]  = '{3'd0, 3'd0, 1'b1, 1'b0, 2, 0, 0, 1'b1};
        vecs[2]  = '{3'd0, 3'd0, 1'b1, 1'b0, 1, 0, 0, 1'b1};
        vecs[3]  = '{3'd0, 3'd0, 1'b1, 1'b0, 0, 0, 0, 1'b1};
        vecs[4]  = '{3'd0, 3'd0, 1'b0, 1'b0, 0, 0, 0, 1'b1};
        vecs[5]  = '{3'd1, 3'd0, 1'b1, 1'b0, 1, 0, 0, 1'b1};
        vecs[6]  = '{3'd2, 3'd0, 1'b1, 1'b0, 1, 0, 1, 1'b1};
        vecs[7]  = '{3'd3, 3'd0, 1'b1, 1'b0, 1, 1, 1, 1'b1};
        vecs[8]  = '{3'd4, 3'd0, 1'b0, 1'b0, 1, 1, 1, 1'b1};
        vecs[9]  = '{3'd5, 3'd2, 1'b0, 1'b0, 1, 1, 1, 1'b1};
        vecs[10] = '{3'd7, 3'd1, 1'b0, 1'b0, 1, 1, 1, 1'b1};

        doReset();

        // Directed table: O piece spawn, walk into the left wall, misc rejects.
        for (int i = 0; i < 11; i++) begin
            doCommand(vecs[i].c, vecs[i].b);
            checkOutput("vec_ok", cap.ok, vecs[i].ok);
            checkOutput("vec_landed", cap.land, vecs[i].land);
            checkOutput("vec_x", cap.x, vecs[i].x);
            checkOutput("vec_y", cap.y, vecs[i].y);
            checkOutput("vec_rot", cap.rot, vecs[i].rot);
            checkOutput("vec_active", cap.act, vecs[i].act);
            if (i == 0) begin
                checkOutput("spawn_reads", read_log.size(), 4);
                if (read_log.size() == 4) begin
                    checkOutput("spawn_rd0", read_log[0], 3 * 32 + 0);
                    checkOutput("spawn_rd1", read_log[1], 4 * 32 + 0);
                    checkOutput("spawn_rd2", read_log[2], 3 * 32 + 1);
                    checkOutput("spawn_rd3", read_log[3], 4 * 32 + 1);
                end
            end
        end

        // I piece falls to the floor and lands; afterwards moves are rejected.
        doReset();
        doCommand(3'd4, 3'd0);
        for (int i = 0; i < 19; i++) doCommand(3'd3, 3'd0);
        checkOutput("floor_y", cap.y, 19);
        doCommand(3'd3, 3'd0);
        checkOutput("land_ok", cap.ok, 0);
        checkOutput("land_pulse", cap.land, 1);
        checkOutput("land_active", cap.act, 0);
        doCommand(3'd0, 3'd0);
        checkOutput("inactive_left_ok", cap.ok, 0);
        checkOutput("inactive_left_land", cap.land, 0);

        // Blocked spawn ends the game; game over is sticky.
        doReset();
        board[0][3] = 1'b1;
        doCommand(3'd4, 3'd0);
        checkOutput("blocked_spawn_ok", cap.ok, 0);
        checkOutput("blocked_spawn_go", cap.go, 1);
        doCommand(3'd4, 3'd3);
        checkOutput("go_spawn_ok", cap.ok, 0);
        checkOutput("go_sticky", cap.go, 1);
        clearBoard();

        // Full rotation cycle, then reset while probing cells.
        doReset();
        doCommand(3'd4, 3'd5);
        for (int i = 1; i <= 4; i++) begin
            doCommand(3'd2, 3'd0);
            checkOutput("rot_cycle", cap.rot, i % 4);
        end
        @(negedge clock);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = 3'd2;
        @(posedge clock);
        #1;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (cmd_if.result_valid) seen++;
        end
        checkOutput("midreset_no_result", seen, 0);
        checkOutput("midreset_active", active, 0);
        checkOutput("midreset_rot", piece_rot, 0);
        checkOutput("midreset_ready", cmd_if.cmd_ready, 1);
        modelReset();

        // Random play against the model.
        randomBoard();
        for (int n = 0; n < 300; n++) begin
            if (m_go) begin
                doReset();
                randomBoard();
            end
            if (!m_act) begin
                c = ($urandom_range(0, 9) < 7) ? 3'd4 : 3'($urandom_range(0, 7));
            end else begin
                r = $urandom_range(0, 19);
                if (r < 5)       c = 3'd0;
                else if (r < 10) c = 3'd1;
                else if (r < 13) c = 3'd2;
                else if (r < 18) c = 3'd3;
                else if (r < 19) c = 3'd4;
                else             c = 3'($urandom_range(5, 7));
            end
            doCommand(c, 3'($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
